// File: rtl/imem_dmem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_port_arbiter_pkg
// Description : Shared types and constants for the I/D memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_dmem_port_arbiter_pkg;

    localparam int unsigned c_lat_cnt_w = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_e;

endpackage
`default_nettype wire

// File: rtl/imem_dmem_port_arbiter_arb_lat_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_lat_counter
// Description : Loadable saturating 4-bit up-counter flagging count == RD_LAT.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_lat_counter
    import imem_dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned RD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_load,
    input  logic i_en,
    output logic o_done
);

    localparam logic [c_lat_cnt_w-1:0] c_target = c_lat_cnt_w'(RD_LAT);
    localparam logic [c_lat_cnt_w-1:0] c_one    = c_lat_cnt_w'(1);

    logic [c_lat_cnt_w-1:0] r_count;

    // Saturates rather than wraps so a stuck enable can never fake a match.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= c_one;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + c_one;
        end
    end

    assign o_done = (r_count == c_target);

endmodule
`default_nettype wire

// File: rtl/imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : imem_dmem_port_arbiter
// Description : Shares one single-port memory between I-fetch refill and D
//               load/store; fixed D>I priority. Optional anti-starvation
//               guard enabled by defining ARB_STARVE_GUARD_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_dmem_port_arbiter
    import imem_dmem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic                i_flush,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_wdone,
    output logic                mem_cs,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    arb_state_e          r_state;
    arb_owner_e          r_owner;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W/8-1:0] r_be;
    logic                r_drop;
    logic [DATA_W-1:0]   r_i_rdata;
    logic [DATA_W-1:0]   r_d_rdata;

    logic w_i_elig;
    logic w_starve_force;
    logic w_pick_d;
    logic w_pick_i;
    logic w_drop_next;
    logic w_lat_done;

    assign w_i_elig = i_req & ~i_flush;

`ifdef ARB_STARVE_GUARD_EN
    localparam logic [c_lat_cnt_w-1:0] c_starve_max = c_lat_cnt_w'(STARVE_MAX);
    logic [c_lat_cnt_w-1:0] r_starve;
    assign w_starve_force = (r_starve == c_starve_max) & w_i_elig;
`else
    assign w_starve_force = 1'b0;
`endif

    assign w_pick_d    = d_req & ~w_starve_force;
    assign w_pick_i    = w_i_elig & ~w_pick_d;
    // A flush in the final WAIT cycle must already gate the rdata capture.
    assign w_drop_next = r_drop | (i_flush & (r_owner == OWN_I));

    arb_lat_counter #(
        .RD_LAT (RD_LAT)
    ) u_lat_counter (
        .clk    (clk),
        .rst    (rst),
        .i_clr  ((r_state != ARB_GRANT) && (r_state != ARB_WAIT)),
        .i_load ((r_state == ARB_GRANT) && !r_we),
        .i_en   ((r_state == ARB_WAIT) && !w_lat_done),
        .o_done (w_lat_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARB_IDLE;
            r_owner   <= OWN_I;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_be      <= '0;
            r_drop    <= 1'b0;
            r_i_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_drop <= 1'b0;
                    if (w_pick_d) begin
                        r_owner <= OWN_D;
                        r_we    <= d_we;
                        r_addr  <= d_addr;
                        r_wdata <= d_wdata;
                        r_be    <= d_be;
                        r_state <= ARB_GRANT;
                    end else if (w_pick_i) begin
                        r_owner <= OWN_I;
                        r_we    <= 1'b0;
                        r_addr  <= i_addr;
                        r_wdata <= '0;
                        r_be    <= '0;
                        r_state <= ARB_GRANT;
                    end
                end
                ARB_GRANT: begin
                    r_drop  <= w_drop_next;
                    r_state <= r_we ? ARB_RESP : ARB_WAIT;
                end
                ARB_WAIT: begin
                    r_drop <= w_drop_next;
                    if (w_lat_done) begin
                        if (r_owner == OWN_D) begin
                            r_d_rdata <= mem_rdata;
                        end else if (!w_drop_next) begin
                            r_i_rdata <= mem_rdata;
                        end
                        r_state <= ARB_RESP;
                    end
                end
                ARB_RESP: begin
                    r_drop  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (r_state == ARB_GRANT) begin
            if (r_owner == OWN_I) begin
                r_starve <= '0;
            end else if (i_req && (r_starve != '1)) begin
                r_starve <= r_starve + 1'b1;
            end
        end else if ((r_state == ARB_IDLE) && !i_req) begin
            r_starve <= '0;
        end
    end
`endif

    assign busy      = (r_state != ARB_IDLE);
    assign mem_cs    = (r_state == ARB_GRANT);
    assign mem_we    = mem_cs & r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_be    = r_be;
    assign i_gnt     = mem_cs & (r_owner == OWN_I);
    assign d_gnt     = mem_cs & (r_owner == OWN_D);
    assign i_rvalid  = (r_state == ARB_RESP) & (r_owner == OWN_I) & ~r_drop;
    assign d_rvalid  = (r_state == ARB_RESP) & (r_owner == OWN_D) & ~r_we;
    assign d_wdone   = (r_state == ARB_RESP) & (r_owner == OWN_D) & r_we;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_imem_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_dmem_port_arbiter
// Description : Scoreboard bench for imem_dmem_port_arbiter with a memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_dmem_port_arbiter;

    localparam int RD_LAT     = 2;
    localparam int STARVE_MAX = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } gnt_t;

    typedef struct {
        logic        we;
        logic [31:0] data;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, i_flush, i_gnt, i_rvalid;
    logic [31:0] i_addr, i_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_wdone;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be;
    logic        mem_cs, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int i_gnt_cyc = 0;
    int d_gnt_cyc = 0;

    gnt_t i_gq[$], d_gq[$];
    rsp_t i_rq[$], d_rq[$];
    bit   order_q[$];

    logic [31:0] dev_mem [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] rd_pipe [RD_LAT];

    imem_dmem_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wdone(d_wdone),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] w,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = w[8*b +: 8];
        return r;
    endfunction

    // Memory macro model: fixed read latency, garbage on the bus otherwise.
    always @(posedge clk) begin
        if (mem_cs && mem_we)
            dev_mem[mem_addr[13:2]] <= merge(dev_mem[mem_addr[13:2]], mem_wdata, mem_be);
        rd_pipe[0] <= (mem_cs && !mem_we) ? dev_mem[mem_addr[13:2]] : $urandom;
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            gnt_t g;
            rsp_t r;
            chk("cs_equals_gnt", {31'd0, mem_cs}, {31'd0, i_gnt | d_gnt});
            if (i_gnt && d_gnt) flag("both_gnt");
            if ((i_gnt || d_gnt || i_rvalid || d_rvalid || d_wdone))
                chk("busy_active", {31'd0, busy}, 1);
            if ((i_gnt || d_gnt) && order_q.size() > 0)
                chk("grant_order_d", {31'd0, d_gnt}, {31'd0, order_q.pop_front()});
            if (i_gnt) begin
                i_gnt_cyc = cyc;
                if (i_gq.size() == 0) flag("unexpected_i_gnt");
                else begin
                    g = i_gq.pop_front();
                    chk("i_mem_addr", mem_addr, g.addr);
                    chk("i_mem_we", {31'd0, mem_we}, 0);
                end
            end
            if (d_gnt) begin
                d_gnt_cyc = cyc;
                if (d_gq.size() == 0) flag("unexpected_d_gnt");
                else begin
                    g = d_gq.pop_front();
                    chk("d_mem_addr", mem_addr, g.addr);
                    chk("d_mem_we", {31'd0, mem_we}, {31'd0, g.we});
                    if (g.we) chk("d_mem_wdata_be", {mem_be, mem_wdata}, {g.be, g.wdata});
                end
            end
            if (i_rvalid) begin
                if (i_rq.size() == 0) flag("unexpected_i_rvalid");
                else begin
                    r = i_rq.pop_front();
                    chk("i_rdata", i_rdata, r.data);
                    chk("i_rvalid_cycle", cyc, i_gnt_cyc + 1 + RD_LAT);
                end
            end
            if (d_rvalid || d_wdone) begin
                if (d_rq.size() == 0) flag("unexpected_d_response");
                else begin
                    r = d_rq.pop_front();
                    chk("d_rsp_kind", {d_rvalid, d_wdone}, {~r.we, r.we});
                    if (!r.we) chk("d_rdata", d_rdata, r.data);
                    chk("d_rsp_cycle", cyc, d_gnt_cyc + 1 + (r.we ? 0 : RD_LAT));
                end
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        do begin @(negedge clk); t++; end while (busy && t < 100);
        if (busy) flag("wait_idle_timeout");
    endtask

    task automatic i_read(input logic [31:0] a, input bit exact, input bit rsp, output int gcyc);
        int n0, t;
        gnt_t g = '{addr: a, we: 1'b0, wdata: 32'd0, be: 4'd0};
        i_gq.push_back(g);
        if (rsp) i_rq.push_back('{we: 1'b0, data: ref_mem[a[13:2]]});
        @(posedge clk); #1;
        n0 = cyc; i_req = 1'b1; i_addr = a;
        t = 0;
        do begin @(negedge clk); t++; end while (!i_gnt && t < 300);
        if (!i_gnt) flag("i_gnt_timeout");
        gcyc = cyc;
        if (exact) chk("i_gnt_cycle", gcyc, n0 + 1);
        @(posedge clk); #1;
        i_req = 1'b0;
    endtask

    task automatic d_op(input bit we, input logic [31:0] a, input logic [31:0] w,
                        input logic [3:0] be, input bit exact);
        int n0, t;
        gnt_t g = '{addr: a, we: we, wdata: w, be: be};
        d_gq.push_back(g);
        if (we) ref_mem[a[13:2]] = merge(ref_mem[a[13:2]], w, be);
        d_rq.push_back('{we: we, data: ref_mem[a[13:2]]});
        @(posedge clk); #1;
        n0 = cyc; d_req = 1'b1; d_we = we; d_addr = a; d_wdata = w; d_be = be;
        t = 0;
        do begin @(negedge clk); t++; end while (!d_gnt && t < 300);
        if (!d_gnt) flag("d_gnt_timeout");
        if (exact) chk("d_gnt_cycle", cyc, n0 + 1);
        @(posedge clk); #1;
        d_req = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, {i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata, d_wdone,
                   mem_cs, mem_we, mem_addr, mem_wdata, mem_be, busy}, '0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int g, cnt, t, dcount;
        bit seq[10];
        for (int k = 0; k < 4096; k++) begin
            dev_mem[k] = init_val(32'(k) << 2);
            ref_mem[k] = init_val(32'(k) << 2);
        end
        dev_mem[16] = 32'hDEADBEEF;
        ref_mem[16] = 32'hDEADBEEF;
        rst = 1'b1; i_req = 0; i_addr = 0; i_flush = 0;
        d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_outputs");
        @(posedge clk); #1 rst = 1'b0;

        // Single I read, single D write, readback and partial write
        wait_idle();
        i_read(32'h40, 1, 1, g);
        wait_idle();
        d_op(1, 32'h80, 32'h12345678, 4'hF, 1);
        wait_idle();
        d_op(0, 32'h80, 32'h0, 4'h0, 1);
        d_op(1, 32'h84, 32'hA1B2C3D4, 4'h5, 0);
        d_op(0, 32'h84, 32'h0, 4'h0, 0);
        wait_idle();

        // Simultaneous requests: D first, then I
        order_q.push_back(1'b1);
        order_q.push_back(1'b0);
        fork
            d_op(0, 32'h80, 32'h0, 4'h0, 0);
            begin int gg; i_read(32'h48, 0, 1, gg); end
        join
        wait_idle();

        // A flushed request in IDLE is not eligible
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h4C; i_flush = 1'b1;
        cnt = 0;
        repeat (4) begin @(negedge clk); if (i_gnt || busy) cnt++; end
        chk("flush_blocks_idle_req", cnt, 0);
        @(posedge clk); #1;
        i_req = 1'b0; i_flush = 1'b0;

        // Flush during WAIT drops the response but keeps the timing
        i_read(32'h4C, 0, 0, g);
        i_flush = 1'b1;
        @(posedge clk); #1;
        i_flush = 1'b0;
        t = 0;
        while (cyc != g + 1 + RD_LAT && t < 20) begin @(negedge clk); t++; end
        chk("flush_resp_busy", {31'd0, busy}, 1);
        @(negedge clk);
        chk("flush_back_to_idle", {31'd0, busy}, 0);
        i_read(32'h44, 0, 1, g);
        wait_idle();

        // Reset during WAIT abandons the access
        i_read(32'h50, 0, 0, g);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset_mid_wait");
        @(posedge clk); #1 rst = 1'b0;
        repeat (RD_LAT + 4) @(negedge clk);

        // Both requesters held continuously
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            if (dcount == STARVE_MAX) begin seq[k] = 1'b0; dcount = 0; end
            else begin seq[k] = 1'b1; dcount++; end
`else
            seq[k] = 1'b1;
`endif
            order_q.push_back(seq[k]);
            if (seq[k]) begin
                d_gq.push_back('{addr: 32'h90, we: 1'b0, wdata: 32'd0, be: 4'd0});
                d_rq.push_back('{we: 1'b0, data: ref_mem[36]});
            end else begin
                i_gq.push_back('{addr: 32'h94, we: 1'b0, wdata: 32'd0, be: 4'd0});
                i_rq.push_back('{we: 1'b0, data: ref_mem[37]});
            end
        end
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = 32'h94;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h90; d_be = 4'h0;
        cnt = 0; t = 0;
        while (cnt < 10 && t < 500) begin
            @(negedge clk); t++;
            if (i_gnt || d_gnt) cnt++;
        end
        chk("held_grant_count", cnt, 10);
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b0;
        wait_idle();

        // Randomized concurrent traffic
        fork
            begin
                for (int k = 0; k < 15; k++) begin
                    int gg;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    i_read(32'h1000 + 4 * $urandom_range(0, 63), 0, 1, gg);
                end
            end
            begin
                for (int k = 0; k < 15; k++) begin
                    logic [3:0] be;
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    be = 4'($urandom_range(1, 15));
                    d_op(1'($urandom_range(0, 1)), 32'h2000 + 4 * $urandom_range(0, 15),
                         $urandom, be, 0);
                end
            end
        join
        wait_idle();
        repeat (RD_LAT + 4) @(negedge clk);
        chk("queues_drained", {i_gq.size(), d_gq.size(), i_rq.size(), d_rq.size()}, '0);
        chk("order_queue_drained", order_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
